// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared types and defaults for the I2C minion register-bank controller.
package i2c_ctrl_pkg;

  localparam int BITS_DEF  = 6;
  localparam int NREGS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    DATA = 2'd2,
    LOCK = 2'd3
  } ctrl_state_t;

  // The top register index is the read-only status slot.
  function automatic int ro_index(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Word-level handshake between the I2C minion core (master) and the register controller (slave).
interface i2c_reg_ctrl_if
  import i2c_ctrl_pkg::*;
#(
  parameter int BITS = BITS_DEF
) ();

  logic            txn_start;
  logic            txn_stop;
  logic            rx_valid;
  logic [BITS-1:0] rx_data;
  logic            tx_req;
  logic [BITS-1:0] tx_data;
  logic            tx_valid;

  modport master (
    output txn_start, txn_stop, rx_valid, rx_data, tx_req,
    input  tx_data, tx_valid
  );

  modport slave (
    input  txn_start, txn_stop, rx_valid, rx_data, tx_req,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/i2c_reg_ctrl_bank.sv
// NREGS x BITS register bank with indexed write and a read mux that substitutes
// status_in at the read-only top index (which has no storage and reads back 0 on regs_out).
module i2c_reg_bank
  import i2c_ctrl_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [BITS-1:0]       wdata,
  input  logic [AW-1:0]         raddr,
  input  logic [BITS-1:0]       status_in,
  output logic [BITS-1:0]       rdata,
  output logic [NREGS*BITS-1:0] regs_out
);

  localparam int RO_IDX = ro_index(NREGS);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == RO_IDX) begin : g_ro
        assign regs_out[gi*BITS +: BITS] = '0;
      end else begin : g_rw
        logic [BITS-1:0] q_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            q_reg <= '0;
          end else if (we && (int'(waddr) == gi)) begin
            q_reg <= wdata;
          end
        end

        assign regs_out[gi*BITS +: BITS] = q_reg;
      end
    end
  endgenerate

  always_comb begin
    rdata = regs_out[int'(raddr)*BITS +: BITS];
    if (int'(raddr) == RO_IDX) begin
      rdata = status_in;
    end
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Pointer-addressed register controller behind the I2C minion core.
// Optional I2C_CTRL_AUTOINC_EN: pointer auto-increments (with wrap) after each DATA access.
module i2c_reg_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_reg_ctrl_if.slave         core,
  input  logic [BITS-1:0]       status_in,
  output logic [NREGS*BITS-1:0] regs_out,
  output logic                  err,
  output logic                  busy
);

  localparam int AW = $clog2(NREGS);

  ctrl_state_t     state_reg, state_next;
  logic [AW-1:0]   ptr_reg, ptr_next, ptr_adv;
  logic            err_reg, err_next;
  logic [BITS-1:0] tx_data_reg, tx_data_next;
  logic            tx_valid_reg, tx_valid_next;
  logic            bank_we;
  logic [BITS-1:0] bank_rdata;

  i2c_reg_bank #(
    .BITS  (BITS),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (bank_we),
    .waddr     (ptr_reg),
    .wdata     (core.rx_data),
    .raddr     (ptr_reg),
    .status_in (status_in),
    .rdata     (bank_rdata),
    .regs_out  (regs_out)
  );

`ifdef I2C_CTRL_AUTOINC_EN
  // NREGS is a power of two, so natural overflow gives the wrap to 0.
  assign ptr_adv = ptr_reg + AW'(1);
`else
  assign ptr_adv = ptr_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      err_reg      <= 1'b0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      err_reg      <= err_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    err_next      = err_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = core.tx_req;
    bank_we       = 1'b0;

    case (state_reg)
      PTR: begin
        if (core.rx_valid) begin
          ptr_next = core.rx_data[AW-1:0];
          if (|core.rx_data[BITS-1:AW]) begin
            err_next   = 1'b1;
            state_next = LOCK;
          end else begin
            err_next   = 1'b0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        bank_we = core.rx_valid;
        if (core.rx_valid || core.tx_req) begin
          ptr_next = ptr_adv;
        end
      end
      default: ;
    endcase

    // A read collides with a write as a protocol violation and is answered with 0.
    if (core.tx_req) begin
      if (!core.rx_valid && (state_reg == PTR || state_reg == DATA)) begin
        tx_data_next = bank_rdata;
      end else begin
        tx_data_next = '0;
      end
    end

    if (core.txn_start) begin
      state_next = PTR;
    end else if (core.txn_stop) begin
      state_next = IDLE;
    end
  end

  assign core.tx_data  = tx_data_reg;
  assign core.tx_valid = tx_valid_reg;
  assign err           = err_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl; read replies are checked against a queue of expected words.
module tb_i2c_reg_ctrl;
  import i2c_ctrl_pkg::*;

  localparam int BITS  = 6;
  localparam int NREGS = 4;

  logic                  clk;
  logic                  rst;
  logic [BITS-1:0]       status_in;
  logic [NREGS*BITS-1:0] regs_out;
  logic                  err;
  logic                  busy;

  i2c_reg_ctrl_if #(.BITS(BITS)) bus ();

  i2c_reg_ctrl #(
    .BITS  (BITS),
    .NREGS (NREGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core      (bus),
    .status_in (status_in),
    .regs_out  (regs_out),
    .err       (err),
    .busy      (busy)
  );

  int              n_pass = 0;
  int              n_total = 0;
  logic [BITS-1:0] exp_q[$];
  logic [BITS-1:0] exp_regs[NREGS];
  logic            req_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      check($sformatf("%s_reg%0d", tag, i), 32'(regs_out[i*BITS +: BITS]), 32'(exp_regs[i]));
    end
  endtask

  // Drives one cycle of core-side pulses; a read pushes its expected reply.
  task automatic pulse(input logic st, input logic sp, input logic rv,
                       input logic [BITS-1:0] rd, input logic tr,
                       input logic [BITS-1:0] texp);
    bus.txn_start = st;
    bus.txn_stop  = sp;
    bus.rx_valid  = rv;
    bus.rx_data   = rd;
    bus.tx_req    = tr;
    if (tr) exp_q.push_back(texp);
    @(posedge clk);
    #1;
    bus.txn_start = 1'b0;
    bus.txn_stop  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.tx_req    = 1'b0;
    $display("txn st=%0b sp=%0b rx=%0b d=0x%02h tx=%0b exp=0x%02h | busy=%0b err=%0b regs=0x%06h",
             st, sp, rv, rd, tr, texp, busy, err, regs_out);
  endtask

  task automatic start();                     pulse(1, 0, 0, '0, 0, '0); endtask
  task automatic stop();                      pulse(0, 1, 0, '0, 0, '0); endtask
  task automatic rx(input logic [BITS-1:0] d); pulse(0, 0, 1, d, 0, '0); endtask
  task automatic txq(input logic [BITS-1:0] e); pulse(0, 0, 0, '0, 1, e); endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) req_d <= 1'b0;
    else     req_d <= bus.tx_req;
  end

  // Every reply must land exactly one cycle after its request and match the queue head.
  always @(negedge clk) begin
    if (!rst && (req_d || bus.tx_valid)) begin
      check("tx_valid_timing", 32'(bus.tx_valid), 32'(req_d));
      if (bus.tx_valid) begin
        check("tx_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    status_in     = '0;
    bus.txn_start = 1'b0;
    bus.txn_stop  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.tx_req    = 1'b0;
    for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;

    // Reset state
    #12;
    check("rst_regs", 32'(regs_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Writes through the pointer
    start();
    check("busy_start", 32'(busy), 32'd1);
    rx(6'h01);
    rx(6'h2A);
    check("wr_visible", 32'(regs_out[1*BITS +: BITS]), 32'h2A);
    rx(6'h15);
    rx(6'h3F);
    check("busy_before_stop", 32'(busy), 32'd1);
    stop();
    check("busy_after_stop", 32'(busy), 32'd0);
`ifdef I2C_CTRL_AUTOINC_EN
    exp_regs[1] = 6'h2A;
    exp_regs[2] = 6'h15;
`else
    exp_regs[1] = 6'h3F;
`endif
    check_regs("t2");
    check("t2_err", 32'(err), 32'd0);

    // Reads, including status substitution and wrap
    start();
    rx(6'h00);
    rx(6'h05);
    stop();
    exp_regs[0] = 6'h05;
    status_in = 6'h33;
    start();
    rx(6'h03);
    txq(6'h33);
    status_in = 6'h21;
`ifdef I2C_CTRL_AUTOINC_EN
    txq(6'h05);
    idle(3);
    check("tx_hold", 32'(bus.tx_data), 32'h05);
`else
    txq(6'h21);
    idle(3);
    check("tx_hold", 32'(bus.tx_data), 32'h21);
`endif
    check("tx_valid_idle", 32'(bus.tx_valid), 32'd0);
    start();
`ifdef I2C_CTRL_AUTOINC_EN
    txq(6'h2A);
`else
    txq(6'h21);
`endif
    stop();
    txq(6'h00);
    check("t3_busy", 32'(busy), 32'd0);
    check_regs("t3");

    // Bad pointer locks out the transaction
    start();
    rx(6'h06);
    check("lock_err", 32'(err), 32'd1);
    check("lock_busy", 32'(busy), 32'd1);
    rx(6'h11);
    check_regs("t4_lock");
    txq(6'h00);
    stop();
    check("err_sticky", 32'(err), 32'd1);
    start();
    rx(6'h00);
    check("err_clear", 32'(err), 32'd0);

    // Repeated START and collisions
    pulse(1, 0, 1, 6'h0C, 0, '0);
    exp_regs[0] = 6'h0C;
    check("rstart_wr", 32'(regs_out[0 +: BITS]), 32'h0C);
    rx(6'h02);
    rx(6'h07);
    exp_regs[2] = 6'h07;
    check_regs("t5_rstart");
    pulse(1, 1, 0, '0, 0, '0);
    check("start_stop_busy", 32'(busy), 32'd1);
    rx(6'h01);
    rx(6'h09);
    pulse(0, 0, 1, 6'h0B, 1, 6'h00);
`ifdef I2C_CTRL_AUTOINC_EN
    exp_regs[1] = 6'h09;
    exp_regs[2] = 6'h0B;
    txq(6'h21);
`else
    exp_regs[1] = 6'h0B;
    txq(6'h0B);
`endif
    check_regs("t5_coll");
    stop();

    // Fixed-pointer behaviour versus auto-increment
    start();
    rx(6'h02);
    rx(6'h10);
    rx(6'h20);
`ifdef I2C_CTRL_AUTOINC_EN
    exp_regs[2] = 6'h10;
`else
    exp_regs[2] = 6'h20;
`endif
    check_regs("t6");
    stop();

    // Asynchronous reset in the middle of DATA
    start();
    rx(6'h01);
    check("pre_rst_busy", 32'(busy), 32'd1);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_regs", 32'(regs_out), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_tx_data", 32'(bus.tx_data), 32'd0);
    check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    check("tx_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
